// File: rtl/key_input_pkg.sv
// key_input_pkg: shared types and default timing for the pushbutton conditioner.
//   key_state_e        - per-key debounce FSM state
//   DEF_*              - default parameter values (50 MHz board timing)
//   max3()             - helper used to size the shared counters
package key_input_pkg;

    // Per-key debounce FSM state
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int unsigned DEF_NUM_KEYS        = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms at 50 MHz
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 100 ms at 50 MHz

    // Largest of three values; used for counter sizing
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one pushbutton channel.
//   2-flop synchronizer -> 4-state debounce FSM -> registered level/press/release.
//   Optional auto-repeat, built only when KEY_AUTOREPEAT_EN is defined.
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   key_n       - raw asynchronous button, 0 = pressed
//   key_level   - debounced state, 1 = held
//   key_press   - one-cycle pulse per accepted press (and per repeat)
//   key_release - one-cycle pulse per accepted release
module key_debounce_channel
    import key_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
    // The sample that causes entry to a WAIT state is not counted, so the
    // last counted sample is DEBOUNCE_CYCLES-1 after a cleared counter.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer: resets to the released level
    logic sync1;
    logic sync2;
    logic pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    key_state_e       state;
    key_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_accept;
    logic             release_accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and debounce counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                end else begin
                    cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_nxt = HELD;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign press_accept   = (state == PRESS_WAIT)   && (state_nxt == HELD);
    assign release_accept = (state == RELEASE_WAIT) && (state_nxt == IDLE);

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_first_done;
    logic             rpt_fire;

    // Fires on the last cycle of the current delay/period window while HELD
    always_comb begin
        rpt_fire = 1'b0;
        if (state == HELD) begin
            rpt_fire = (rpt_cnt == (rpt_first_done ? RPT_PERIOD_LAST : RPT_DELAY_LAST));
        end
    end

    // Repeat timer: restarts on HELD entry, advances only in HELD, so it
    // freezes through RELEASE_WAIT and resumes on a bounce back to HELD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt        <= '0;
            rpt_first_done <= 1'b0;
        end else if (press_accept) begin
            rpt_cnt        <= '0;
            rpt_first_done <= 1'b0;
        end else if (state == HELD) begin
            if (rpt_fire) begin
                rpt_cnt        <= '0;
                rpt_first_done <= 1'b1;
            end else begin
                rpt_cnt <= (rpt_cnt == CNT_SAT) ? rpt_cnt : rpt_cnt + CNT_W'(1);
            end
        end
    end
`endif

    logic level_nxt;
    logic press_nxt;
    logic release_nxt;

    // Output next values; level only changes on accepted transitions
    always_comb begin
        level_nxt   = key_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        if (press_accept) begin
            level_nxt = 1'b1;
            press_nxt = 1'b1;
        end
        if (release_accept) begin
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
        end
`ifdef KEY_AUTOREPEAT_EN
        if (rpt_fire) begin
            press_nxt = 1'b1;
        end
`endif
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

endmodule

// File: rtl/key_input_conditioner.sv
// key_input_conditioner: NUM_KEYS independent debounced pushbutton channels.
//   Optional auto-repeat on KEY_PRESS when KEY_AUTOREPEAT_EN is defined.
// Ports:
//   CLK         - clock, rising edge
//   RST_N       - asynchronous active-low reset
//   KEY_N       - raw asynchronous buttons, 0 = pressed
//   KEY_LEVEL   - debounced state per key, 1 = held
//   KEY_PRESS   - one-cycle pulse per accepted press (and per repeat)
//   KEY_RELEASE - one-cycle pulse per accepted release
module key_input_conditioner
    import key_input_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = DEF_NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_KEYS-1:0] KEY_N,
    output logic [NUM_KEYS-1:0] KEY_LEVEL,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE
);

    // One fully independent channel per key
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (CLK),
            .rst_n       (RST_N),
            .key_n       (KEY_N[i]),
            .key_level   (KEY_LEVEL[i]),
            .key_press   (KEY_PRESS[i]),
            .key_release (KEY_RELEASE[i])
        );
    end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Stimulus pushes expected pulse events; a monitor pops
// and compares whenever KEY_PRESS or KEY_RELEASE is non-zero.
module tb_key_input_conditioner;

    localparam int unsigned NK = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [NK-1:0] KEY_N;
    logic [NK-1:0] KEY_LEVEL;
    logic [NK-1:0] KEY_PRESS;
    logic [NK-1:0] KEY_RELEASE;

    key_input_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .KEY_N       (KEY_N),
        .KEY_LEVEL   (KEY_LEVEL),
        .KEY_PRESS   (KEY_PRESS),
        .KEY_RELEASE (KEY_RELEASE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] level;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int at, input logic [NK-1:0] p,
                             input logic [NK-1:0] r, input logic [NK-1:0] l);
        exp_t e;
        e.at = at;
        e.press = p;
        e.rel = r;
        e.level = l;
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        RST_N = 1'b0;
        KEY_N = '1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    // Monitor: compare every presented pulse against the next expectation
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N === 1'b1 && (KEY_PRESS != '0 || KEY_RELEASE != '0)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {24'd0, KEY_PRESS, KEY_RELEASE}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.at);
                check("pulse_press", KEY_PRESS, e.press);
                check("pulse_release", KEY_RELEASE, e.rel);
                check("pulse_level", KEY_LEVEL, e.level);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;

        // Reset values
        RST_N = 1'b0;
        KEY_N = '1;
        repeat (3) @(negedge CLK);
        check("rst_level", KEY_LEVEL, 0);
        check("rst_press", KEY_PRESS, 0);
        check("rst_release", KEY_RELEASE, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Clean press on key 0, held 30 cycles
        KEY_N[0] = 1'b0;
        t0 = cyc + 1;
        expect_at(t0 + 6, 4'b0001, 4'b0000, 4'b0001);
`ifdef KEY_AUTOREPEAT_EN
        expect_at(t0 + 26, 4'b0001, 4'b0000, 4'b0001);
`endif
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            check("clean_level0", KEY_LEVEL[0], (cyc >= t0 + 6) ? 1 : 0);
            check("clean_others", KEY_LEVEL[3:1], 0);
        end
        KEY_N[0] = 1'b1;
        t1 = cyc + 1;
        expect_at(t1 + 6, 4'b0000, 4'b0001, 4'b0000);
        repeat (12) @(negedge CLK);
        reset_dut();

        // Bounce on key 1: 2 low / 2 high for 20 cycles, then high
        for (int i = 0; i < 5; i++) begin
            KEY_N[1] = 1'b0;
            repeat (2) begin
                @(negedge CLK);
                check("bounce_level1", KEY_LEVEL[1], 0);
            end
            KEY_N[1] = 1'b1;
            repeat (2) begin
                @(negedge CLK);
                check("bounce_level1", KEY_LEVEL[1], 0);
            end
        end
        repeat (10) begin
            @(negedge CLK);
            check("bounce_level1", KEY_LEVEL[1], 0);
        end
        reset_dut();

        // Release glitch on key 2, then a clean release
        KEY_N[2] = 1'b0;
        t0 = cyc + 1;
        expect_at(t0 + 6, 4'b0100, 4'b0000, 4'b0100);
        repeat (12) @(negedge CLK);
        KEY_N[2] = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            check("glitch_level2", KEY_LEVEL[2], 1);
        end
        KEY_N[2] = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            check("glitch_level2", KEY_LEVEL[2], 1);
        end
        KEY_N[2] = 1'b1;
        t1 = cyc + 1;
        expect_at(t1 + 6, 4'b0000, 4'b0100, 4'b0000);
        repeat (12) @(negedge CLK);
        reset_dut();

        // Simultaneous press and release on all keys
        KEY_N = 4'b0000;
        t0 = cyc + 1;
        expect_at(t0 + 6, 4'b1111, 4'b0000, 4'b1111);
        repeat (10) @(negedge CLK);
        KEY_N = 4'b1111;
        t1 = cyc + 1;
        expect_at(t1 + 6, 4'b0000, 4'b1111, 4'b0000);
        repeat (12) @(negedge CLK);
        reset_dut();

        // Reset at cycle 3 of a press, key still held afterwards
        KEY_N[0] = 1'b0;
        t0 = cyc + 1;
        repeat (4) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("midrst_level", KEY_LEVEL, 0);
        check("midrst_press", KEY_PRESS, 0);
        check("midrst_release", KEY_RELEASE, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        t1 = cyc + 1;
        expect_at(t1 + 6, 4'b0001, 4'b0000, 4'b0001);
        repeat (9) @(negedge CLK);
        check("held_level_before_rst", KEY_LEVEL, 4'b0001);
        // Reset while held clears level asynchronously with no release pulse
        RST_N = 1'b0;
        #1;
        check("heldrst_level", KEY_LEVEL, 0);
        check("heldrst_release", KEY_RELEASE, 0);
        @(negedge CLK);
        KEY_N = '1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);

        // Long hold on key 3 (auto-repeat when enabled)
        KEY_N[3] = 1'b0;
        t0 = cyc + 1;
        expect_at(t0 + 6, 4'b1000, 4'b0000, 4'b1000);
`ifdef KEY_AUTOREPEAT_EN
        expect_at(t0 + 26, 4'b1000, 4'b0000, 4'b1000);
        expect_at(t0 + 34, 4'b1000, 4'b0000, 4'b1000);
        expect_at(t0 + 42, 4'b1000, 4'b0000, 4'b1000);
        expect_at(t0 + 50, 4'b1000, 4'b0000, 4'b1000);
        expect_at(t0 + 58, 4'b1000, 4'b0000, 4'b1000);
`endif
        repeat (60) @(negedge CLK);
        KEY_N[3] = 1'b1;
        t1 = cyc + 1;
        expect_at(t1 + 6, 4'b0000, 4'b1000, 4'b0000);
        repeat (12) @(negedge CLK);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_input_conditioner.md
KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, meaning the number of independent pushbutton channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the stable-sample count required to accept a level change (20 ms at 50 MHz); legal range is at least 2.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000, meaning the cycles of continuous hold before the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5000000, meaning the cycles between subsequent auto-repeats.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port KEY_N, input, NUM_KEYS bits: raw asynchronous pushbuttons, where 0 means pressed.
REQ-008 SHALL have port KEY_LEVEL, output, NUM_KEYS bits: debounced state, where 1 means held.
REQ-009 SHALL have port KEY_PRESS, output, NUM_KEYS bits: a one-cycle pulse per accepted press, and per repeat when REQ-022 applies.
REQ-010 SHALL have port KEY_RELEASE, output, NUM_KEYS bits: a one-cycle pulse per accepted release.

Function
REQ-011 SHALL pass each KEY_N bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL implement a per-key FSM with four states:
- IDLE: released and stable.
- PRESS_WAIT: candidate press.
- HELD: pressed and stable.
- RELEASE_WAIT: candidate release.
REQ-013 SHALL apply these FSM transitions:
- IDLE -> PRESS_WAIT when the synchronized input reads pressed; the counter clears.
- PRESS_WAIT -> IDLE on any released sample (bounce); no output.
- PRESS_WAIT -> HELD after DEBOUNCE_CYCLES consecutive pressed samples.
REQ-014 SHALL apply these FSM transitions:
- HELD -> RELEASE_WAIT on a released sample; the counter clears.
- RELEASE_WAIT -> HELD on any pressed sample.
- RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive released samples.
REQ-015 SHALL, on entry to HELD from PRESS_WAIT, set KEY_LEVEL to 1 and pulse KEY_PRESS for exactly one cycle, both registered in the same cycle.
REQ-016 SHALL, on entry to IDLE from RELEASE_WAIT, clear KEY_LEVEL and pulse KEY_RELEASE for exactly one cycle.
REQ-017 SHALL give a total latency of exactly DEBOUNCE_CYCLES+2 clock cycles from the first rising edge that samples a clean KEY_N transition to the corresponding KEY_PRESS or KEY_RELEASE pulse.
REQ-018 SHALL keep KEY_LEVEL at 1 throughout RELEASE_WAIT and at 0 throughout PRESS_WAIT, so that glitches never reach KEY_LEVEL.
REQ-019 SHALL keep channels fully independent; simultaneous pulses on several bits in the same cycle are legal and required.
REQ-020 SHALL size each debounce counter as $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1) bits and saturate it, never wrapping.

Reset
REQ-021 SHALL, while RST_N=0 (asynchronously), hold:
- KEY_LEVEL, KEY_PRESS and KEY_RELEASE at 0.
- The synchronizer flops at the released value (1).
- The FSMs in IDLE and the counters at 0.
A key held across reset deassertion SHALL be debounced as a new press. Reset asserted mid-debounce or mid-repeat SHALL abort that activity with no pulse.

Configuration
REQ-022 SHALL, when macro KEY_AUTOREPEAT_EN is defined, re-pulse KEY_PRESS for one cycle in HELD after REPEAT_DELAY further cycles, then every REPEAT_PERIOD cycles, while held.
- The repeat timer SHALL restart on each HELD entry.
- The repeat timer SHALL freeze, without pulsing, during RELEASE_WAIT.
- The repeat timer SHALL resume on a return to HELD from RELEASE_WAIT.
REQ-023 SHALL, when KEY_AUTOREPEAT_EN is undefined, generate no repeat logic, so exactly one KEY_PRESS occurs per accepted press; REPEAT_DELAY and REPEAT_PERIOD are then ignored.

Structure
REQ-024 SHALL place the FSM state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the default timing constants in shared package key_input_pkg.
REQ-025 SHALL implement one channel in sub-module key_debounce_channel, which contains the synchronizer, FSM, counter and repeat timer; the top SHALL instantiate NUM_KEYS copies via generate.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
REQ-026 Clean press: KEY_N[0] goes 1->0 and holds 30 cycles -> KEY_PRESS[0] is high for exactly one cycle at cycle 6; KEY_LEVEL[0]=1 from cycle 6; other bits stay 0.
REQ-027 Bounce: KEY_N[1] toggles 0/1 every 2 cycles for 20 cycles, then holds 1 -> no KEY_PRESS[1] and KEY_LEVEL[1]=0 throughout.
REQ-028 Release glitch: hold KEY_N[2] low, release for 2 cycles, then low again -> KEY_LEVEL[2] stays 1 with no KEY_RELEASE; a clean release then gives KEY_RELEASE[2] six cycles later.
REQ-029 Simultaneous: KEY_N 1111->0000 in one cycle -> KEY_PRESS=1111 in the same cycle, cycle 6.
REQ-030 Reset mid-operation: RST_N low at cycle 3 of a press -> all outputs 0 immediately; after deassertion with the key still held, KEY_PRESS comes 6 cycles later.
REQ-031 Auto-repeat (KEY_AUTOREPEAT_EN defined): hold KEY_N[3] low for 60 cycles -> KEY_PRESS[3] pulses at cycles 6, 26, 34, 42, 50, 58; with the macro undefined, only cycle 6.
